// File: rtl/clock_monitor.sv
// -----------------------------------------------------------------------------
// clock_monitor
//
// Observes a slow, asynchronous clock (typically a divider output) by sampling
// it as data in the fast clk_in domain. Produces single-cycle edge strobes,
// measures the high/low segment lengths and the period in clk_in cycles,
// declares lock once the period has repeated LOCK_COUNT times, and raises a
// timeout when the monitored clock stops toggling long enough to saturate the
// segment counter.
//
// Parameters
//   CNT_W       width of the segment counter and of high_len/low_len
//   LOCK_COUNT  consecutive equal-period comparisons needed for lock (1..15)
//
// Ports
//   clk_in        fast sampling clock
//   rst           asynchronous reset, active low
//   sig_in        monitored slow clock (asynchronous to clk_in)
//   rise          one-cycle strobe on each synchronized rising edge
//   fall          one-cycle strobe on each synchronized falling edge
//   high_len      length of the last complete high segment
//   low_len       length of the last complete low segment
//   period        low_len + preceding high_len, updated on rise
//   period_valid  one-cycle pulse when period updates
//   locked        period stable for LOCK_COUNT comparisons
//   timeout       segment counter saturated; held until the next edge
// -----------------------------------------------------------------------------
module clock_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    S_WAIT_EDGE = 2'd0,
    S_MEASURE   = 2'd1,
    S_LOCKED    = 2'd2
  } state_t;

  // Saturating increment of the segment counter; holding at CNT_MAX is what
  // lets a stopped clock be detected.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Saturating increment of the 4-bit match counter.
  function automatic logic [3:0] sat_inc_match(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t state, state_nxt;

  logic s1, s2, s3;
  logic strobe;
  logic [CNT_W-1:0] seg_cnt;

  logic             have_high, have_high_nxt;
  logic             have_low,  have_low_nxt;
  logic             prev_valid, prev_valid_nxt;
  logic [CNT_W:0]   prev_period, prev_period_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic [3:0]       match_inc;

  logic [CNT_W-1:0] high_len_nxt, low_len_nxt;
  logic [CNT_W:0]   period_nxt, new_period;
  logic             pv_nxt, locked_nxt, timeout_nxt;

  logic             vld_p1, vld_p1_nxt;
  logic             eq_p1,  eq_p1_nxt;

  logic             measuring;
  logic             to_hit;

  // ---- stage 0: synchronizer and edge strobes ------------------------------
  // s1/s2 form the two-flop synchronizer; s3 is the delayed copy used purely
  // for edge detection, so rise/fall are decoded from flops only.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;
  assign strobe = rise | fall;

  // Loading 1 on a strobe makes seg_cnt, at the next strobe, equal to the
  // number of cycles s2 spent at the level that just ended.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      seg_cnt <= '0;
    end else if (strobe) begin
      seg_cnt <= CNT_ONE;
    end else begin
      seg_cnt <= sat_inc_cnt(seg_cnt);
    end
  end

  assign measuring  = (state != S_WAIT_EDGE);
  // A strobe in the saturation cycle is a genuine edge, so it wins.
  assign to_hit     = measuring && (seg_cnt == CNT_MAX) && !strobe;
  assign new_period = {1'b0, seg_cnt} + {1'b0, high_len};
  assign match_inc  = sat_inc_match(match_cnt);

  // ---- stage 1: period comparison result (vld_p1/eq_p1) drives the FSM ----
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= S_WAIT_EDGE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_EDGE: begin
        if (strobe) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (to_hit) begin
          state_nxt = S_WAIT_EDGE;
        end else if (vld_p1 && eq_p1 && (match_inc >= LOCK_TGT)) begin
          state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (to_hit) begin
          state_nxt = S_WAIT_EDGE;
        end else if (vld_p1 && !eq_p1) begin
          state_nxt = S_MEASURE;
        end
      end
      default: state_nxt = S_WAIT_EDGE;
    endcase
  end

  always_comb begin
    high_len_nxt    = high_len;
    low_len_nxt     = low_len;
    period_nxt      = period;
    pv_nxt          = 1'b0;
    have_high_nxt   = have_high;
    have_low_nxt    = have_low;
    prev_valid_nxt  = prev_valid;
    prev_period_nxt = prev_period;
    match_nxt       = match_cnt;
    vld_p1_nxt      = 1'b0;
    eq_p1_nxt       = 1'b0;
    // locked is simply the registered view of the LOCKED state.
    locked_nxt      = (state_nxt == S_LOCKED);

    if (to_hit) begin
      timeout_nxt = 1'b1;
    end else if (strobe) begin
      timeout_nxt = 1'b0;
    end else begin
      timeout_nxt = timeout;
    end

    if (!measuring) begin
      // The segment in progress when we arrive here is partial: the strobe
      // only starts measurement, nothing is captured.
      if (strobe) begin
        have_high_nxt  = 1'b0;
        have_low_nxt   = 1'b0;
        prev_valid_nxt = 1'b0;
        match_nxt      = 4'd0;
      end
    end else if (to_hit) begin
      // No edge closed this segment, so there is nothing to capture.
      match_nxt = 4'd0;
    end else begin
      if (fall) begin
        high_len_nxt  = seg_cnt;
        have_high_nxt = 1'b1;
      end
      if (rise) begin
        low_len_nxt  = seg_cnt;
        have_low_nxt = 1'b1;
        if (have_high) begin
          period_nxt      = new_period;
          pv_nxt          = 1'b1;
          prev_period_nxt = new_period;
          prev_valid_nxt  = 1'b1;
          vld_p1_nxt      = prev_valid;
          eq_p1_nxt       = (new_period == prev_period);
        end
      end
      if (vld_p1) begin
        match_nxt = eq_p1 ? match_inc : 4'd0;
      end
    end
  end

  // ---- stage 1 / output registers ------------------------------------------
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      high_len     <= '0;
      low_len      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      have_high    <= 1'b0;
      have_low     <= 1'b0;
      prev_valid   <= 1'b0;
      prev_period  <= '0;
      match_cnt    <= 4'd0;
      vld_p1       <= 1'b0;
      eq_p1        <= 1'b0;
    end else begin
      high_len     <= high_len_nxt;
      low_len      <= low_len_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      locked       <= locked_nxt;
      timeout      <= timeout_nxt;
      have_high    <= have_high_nxt;
      have_low     <= have_low_nxt;
      prev_valid   <= prev_valid_nxt;
      prev_period  <= prev_period_nxt;
      match_cnt    <= match_nxt;
      vld_p1       <= vld_p1_nxt;
      eq_p1        <= eq_p1_nxt;
    end
  end

endmodule
